if3: RTL and testbench

- Third instruction-fetch stage; sits directly downstream of if2.
- Consumes if2's physical word address (if2_paddr_out) via valid/ready handshake.
- Performs one instruction-memory read per address over a simple strobe/acknowledge bus, with a bus-error timeout.
- Presents fetched word, address and error flag to the decode side through a registered valid/ready output.

---
 rtl/if3_if.sv | 50 +++++
 rtl/if3.sv | 101 ++++++++++
 tb/tb_if3.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/if3_if.sv
// if3 stage bus bundle: if2 address handshake, decode-side output and memory read bus.
interface if3_if;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              if3_ready_out;
    logic              if3_valid_in;
    logic [ADDR_W-1:0] if3_paddr_in;
    logic              if3_ready_in;
    logic              if3_valid_out;
    logic [ADDR_W-1:0] if3_paddr_out;
    logic [DATA_W-1:0] if3_instr_out;
    logic              if3_buserr_out;
    logic              mem_stb_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_ack_in;
    logic [DATA_W-1:0] mem_data_in;

    // Stage-side view
    modport slave (
        output if3_ready_out,
        input  if3_valid_in,
        input  if3_paddr_in,
        input  if3_ready_in,
        output if3_valid_out,
        output if3_paddr_out,
        output if3_instr_out,
        output if3_buserr_out,
        output mem_stb_out,
        output mem_addr_out,
        input  mem_ack_in,
        input  mem_data_in
    );

    // Environment-side view (if2, decode and memory)
    modport master (
        input  if3_ready_out,
        output if3_valid_in,
        output if3_paddr_in,
        output if3_ready_in,
        input  if3_valid_out,
        input  if3_paddr_out,
        input  if3_instr_out,
        input  if3_buserr_out,
        input  mem_stb_out,
        input  mem_addr_out,
        output mem_ack_in,
        output mem_data_in
    );
endinterface

// File: rtl/if3.sv
// if3: third fetch stage. One memory read per accepted address, with a bus-error
// timeout, result held in a single output register until decode takes it.
module if3 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    if3_if.slave bus
);
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              buserr_q, buserr_d;

    // State and datapath registers; reset abandons any in-flight request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            paddr_q  <= '0;
            instr_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            paddr_q  <= paddr_d;
            instr_q  <= instr_d;
            buserr_q <= buserr_d;
        end
    end

    // Next-state and datapath update; an ack in the timeout cycle wins over the error
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        paddr_d  = paddr_q;
        instr_d  = instr_q;
        buserr_d = buserr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.if3_valid_in) begin
                    addr_d  = bus.if3_paddr_in;
                    paddr_d = bus.if3_paddr_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack_in) begin
                    instr_d  = bus.mem_data_in;
                    buserr_d = 1'b0;
                    state_d  = FULL;
                end else if (cnt_q == CNT_LAST) begin
                    instr_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = FULL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FULL: begin
                if (bus.if3_ready_in) begin
                    if (bus.if3_valid_in) begin
                        addr_d  = bus.if3_paddr_in;
                        paddr_d = bus.if3_paddr_in;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready follows downstream ready combinationally while the output is occupied
    assign bus.if3_ready_out  = (state_q == IDLE) || ((state_q == FULL) && bus.if3_ready_in);
    assign bus.mem_stb_out    = (state_q == BUSY);
    assign bus.mem_addr_out   = addr_q;
    assign bus.if3_valid_out  = (state_q == FULL);
    assign bus.if3_paddr_out  = paddr_q;
    assign bus.if3_instr_out  = instr_q;
    assign bus.if3_buserr_out = buserr_q;
endmodule

// File: tb/tb_if3.sv
// Bench for if3: directed scenarios plus randomized fetch transactions, each
// checked against a transaction-level expectation (stb length, result word, error).
module tb_if3;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [29:0] exp_paddr;
    logic [31:0] exp_instr;
    logic        exp_buserr;

    always #5 clk = ~clk;

    if3_if bus ();

    if3 #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Present an address while the stage is idle; it is accepted at the next edge
    task automatic issue(input logic [29:0] a);
        bus.if3_valid_in = 1'b1;
        bus.if3_paddr_in = a;
        bus.mem_ack_in   = 1'($urandom);
        bus.mem_data_in  = 32'($urandom);
        settle();
        chk("issue ready_out", 64'(bus.if3_ready_out), 64'(1));
        chk("issue stb", 64'(bus.mem_stb_out), 64'(0));
        next_cycle();
        bus.if3_valid_in = 1'b0;
        bus.mem_ack_in   = 1'b0;
    endtask

    // Memory phase: ack after dly wait cycles (dly >= TO means no ack in time)
    task automatic complete(input logic [29:0] a, input int dly, input logic [31:0] d);
        int n;
        n = (dly < int'(TO)) ? dly + 1 : int'(TO);
        for (int i = 0; i < n; i++) begin
            bus.mem_ack_in  = (i == dly);
            bus.mem_data_in = (i == dly) ? d : 32'($urandom);
            settle();
            chk("busy stb", 64'(bus.mem_stb_out), 64'(1));
            chk("busy addr", 64'(bus.mem_addr_out), 64'(a));
            chk("busy ready_out", 64'(bus.if3_ready_out), 64'(0));
            chk("busy valid_out", 64'(bus.if3_valid_out), 64'(0));
            next_cycle();
        end
        bus.mem_ack_in = 1'b0;
        exp_paddr  = a;
        exp_instr  = (dly < int'(TO)) ? d : 32'h0;
        exp_buserr = (dly >= int'(TO));
        settle();
        chk("done stb", 64'(bus.mem_stb_out), 64'(0));
        chk("done valid_out", 64'(bus.if3_valid_out), 64'(1));
        chk("done paddr", 64'(bus.if3_paddr_out), 64'(exp_paddr));
        chk("done instr", 64'(bus.if3_instr_out), 64'(exp_instr));
        chk("done buserr", 64'(bus.if3_buserr_out), 64'(exp_buserr));
    endtask

    // Hold the output for `hold` cycles under backpressure with stray acks, then hand off
    task automatic release_out(input int hold, input logic nv, input logic [29:0] na,
                               input logic [31:0] stray);
        for (int h = 0; h < hold; h++) begin
            bus.if3_ready_in = 1'b0;
            bus.if3_valid_in = nv;
            bus.if3_paddr_in = na;
            bus.mem_ack_in   = 1'b1;
            bus.mem_data_in  = stray;
            settle();
            chk("hold valid_out", 64'(bus.if3_valid_out), 64'(1));
            chk("hold paddr", 64'(bus.if3_paddr_out), 64'(exp_paddr));
            chk("hold instr", 64'(bus.if3_instr_out), 64'(exp_instr));
            chk("hold buserr", 64'(bus.if3_buserr_out), 64'(exp_buserr));
            chk("hold ready_out", 64'(bus.if3_ready_out), 64'(0));
            chk("hold stb", 64'(bus.mem_stb_out), 64'(0));
            next_cycle();
        end
        bus.mem_ack_in   = 1'b0;
        bus.if3_ready_in = 1'b1;
        bus.if3_valid_in = nv;
        bus.if3_paddr_in = na;
        settle();
        chk("handoff ready_out", 64'(bus.if3_ready_out), 64'(1));
        chk("handoff valid_out", 64'(bus.if3_valid_out), 64'(1));
        next_cycle();
        bus.if3_ready_in = 1'b0;
        bus.if3_valid_in = 1'b0;
        if (!nv) begin
            settle();
            chk("idle valid_out", 64'(bus.if3_valid_out), 64'(0));
            chk("idle ready_out", 64'(bus.if3_ready_out), 64'(1));
            chk("idle stb", 64'(bus.mem_stb_out), 64'(0));
        end
    endtask

    initial begin
        logic [29:0] a;
        logic [29:0] na;
        logic [31:0] d;
        int          dly;
        int          hold;
        logic        nv;
        logic        pending;

        rst              = 1'b0;
        bus.if3_valid_in = 1'b0;
        bus.if3_paddr_in = '0;
        bus.if3_ready_in = 1'b0;
        bus.mem_ack_in   = 1'b0;
        bus.mem_data_in  = '0;

        // Reset values
        next_cycle();
        next_cycle();
        settle();
        chk("rst valid_out", 64'(bus.if3_valid_out), 64'(0));
        chk("rst paddr", 64'(bus.if3_paddr_out), 64'(0));
        chk("rst instr", 64'(bus.if3_instr_out), 64'(0));
        chk("rst buserr", 64'(bus.if3_buserr_out), 64'(0));
        chk("rst stb", 64'(bus.mem_stb_out), 64'(0));
        chk("rst mem_addr", 64'(bus.mem_addr_out), 64'(0));
        chk("rst ready_out", 64'(bus.if3_ready_out), 64'(1));
        rst = 1'b1;
        next_cycle();

        // Zero-wait fetch
        issue(30'h0000100E);
        complete(30'h0000100E, 0, 32'hDEADBEEF);
        release_out(0, 1'b0, 30'h0, 32'h0);

        // Wait states
        issue(30'h00002004);
        complete(30'h00002004, 3, 32'h12345678);
        release_out(2, 1'b0, 30'h0, 32'h11111111);

        // Backpressure then back-to-back handoff
        issue(30'h00003000);
        complete(30'h00003000, 0, 32'hA5A5A5A5);
        release_out(5, 1'b1, 30'h0000100F, 32'h22222222);
        complete(30'h0000100F, 1, 32'h0F0F0F0F);
        release_out(0, 1'b0, 30'h0, 32'h0);

        // Timeout, late ack with CAFEF00D ignored
        issue(30'h00004000);
        complete(30'h00004000, 99, 32'h0);
        release_out(3, 1'b0, 30'h0, 32'hCAFEF00D);

        // Ack in the timeout cycle
        issue(30'h00005000);
        complete(30'h00005000, int'(TO) - 1, 32'h0000ABCD);
        release_out(1, 1'b0, 30'h0, 32'h33333333);

        // Reset during the second busy cycle
        issue(30'h00006000);
        bus.mem_ack_in = 1'b0;
        settle();
        chk("rstmid stb1", 64'(bus.mem_stb_out), 64'(1));
        next_cycle();
        rst = 1'b0;
        settle();
        chk("rstmid stb2", 64'(bus.mem_stb_out), 64'(1));
        next_cycle();
        rst = 1'b1;
        settle();
        chk("rstmid stb", 64'(bus.mem_stb_out), 64'(0));
        chk("rstmid valid_out", 64'(bus.if3_valid_out), 64'(0));
        chk("rstmid ready_out", 64'(bus.if3_ready_out), 64'(1));
        chk("rstmid paddr", 64'(bus.if3_paddr_out), 64'(0));
        issue(30'h00000001);
        complete(30'h00000001, 2, 32'h76543210);
        release_out(1, 1'b0, 30'h0, 32'h44444444);

        // Randomized transactions
        pending = 1'b0;
        na      = '0;
        for (int it = 0; it < 30; it++) begin
            d   = 32'($urandom);
            dly = int'($urandom_range(0, 5));
            if (pending) begin
                a = na;
            end else begin
                a = 30'($urandom);
                issue(a);
            end
            complete(a, dly, d);
            hold = int'($urandom_range(0, 3));
            nv   = 1'($urandom);
            na   = 30'($urandom);
            release_out(hold, nv, na, 32'($urandom));
            pending = nv;
        end
        if (pending) begin
            complete(na, 0, 32'h13579BDF);
            release_out(0, 1'b0, 30'h0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
